// File: rtl/syn_up_counter_mod.sv
`default_nettype none
// ============================================================================
// Module   : syn_up_counter_mod
// Brief    : Synchronous modulo-MODULUS up counter with enable, clamped
//            parallel load and combinational terminal count for cascading.
//            Define SYN_UP_COUNTER_OVF_EN to add the sticky ovf flag/ovf_clr.
// Revision : 1.0
// ============================================================================
module syn_up_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc
`ifdef SYN_UP_COUNTER_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf
`endif
);

  generate
    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
      $error("syn_up_counter_mod: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_load_q;
  logic [WIDTH-1:0] w_inc_q;
  logic             w_at_max;

  assign w_at_max = (r_q == c_max);
  // Out-of-range load values saturate at the terminal count.
  assign w_load_q = (load_val > c_max) ? c_max : load_val;
  // Explicit wrap covers both non power-of-two moduli and natural rollover.
  assign w_inc_q  = w_at_max ? '0 : r_q + 1'b1;

  assign tc = en & ~load & w_at_max;
  assign Q  = r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_load_q;
    end else if (en) begin
      r_q <= w_inc_q;
    end
  end

`ifdef SYN_UP_COUNTER_OVF_EN
  logic r_ovf;

  // Set beats clear so a wrap coinciding with ovf_clr is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (tc) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_syn_up_counter_mod.sv
`default_nettype none
// Scoreboard bench: driver pushes hand-computed expectations, monitor pops and compares.
module tb_syn_up_counter_mod;

  typedef struct {
    logic       r, e, l, clr;
    logic [3:0] lv;
    logic       exp_tc;
    logic [3:0] exp_q;
    bit         c2;
    logic [3:0] exp_q2;
    bit         c16;
    logic       exp_tc16;
    logic [3:0] exp_q16;
    bit         co;
    logic       exp_ovf;
    string      nm;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] q, q2, q16;
  logic       tc, tc2, tc16;
`ifdef SYN_UP_COUNTER_OVF_EN
  logic       ovf_clr = 1'b0;
  logic       ovf, ovf2, ovf16;
`endif

  int   n_pass = 0;
  int   n_tot  = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  syn_up_counter_mod #(.WIDTH(4), .MODULUS(10)) u_dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .Q(q), .tc(tc)
`ifdef SYN_UP_COUNTER_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf)
`endif
  );

  // Second decade of the cascade, advanced by the first stage's tc.
  syn_up_counter_mod #(.WIDTH(4), .MODULUS(10)) u_s2 (
    .clk(clk), .reset(reset), .en(tc), .load(1'b0), .load_val(4'd0),
    .Q(q2), .tc(tc2)
`ifdef SYN_UP_COUNTER_OVF_EN
    , .ovf_clr(1'b0), .ovf(ovf2)
`endif
  );

  syn_up_counter_mod #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .Q(q16), .tc(tc16)
`ifdef SYN_UP_COUNTER_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf16)
`endif
  );

  function automatic vec_t mk(input logic r, e, l, input logic [3:0] lv,
                              input logic et, input logic [3:0] eq, input string nm);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.lv = lv; v.clr = 1'b0;
    v.exp_tc = et; v.exp_q = eq;
    v.c2 = 0; v.exp_q2 = 4'd0;
    v.c16 = 0; v.exp_tc16 = 1'b0; v.exp_q16 = 4'd0;
    v.co = 0; v.exp_ovf = 1'b0;
    v.nm = nm;
    return v;
  endfunction

  task automatic step(input vec_t v);
    @(negedge clk);
    reset = v.r; en = v.e; load = v.l; load_val = v.lv;
`ifdef SYN_UP_COUNTER_OVF_EN
    ovf_clr = v.clr;
`endif
    sb.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Monitor: tc is sampled mid-cycle, Q/ovf just after the edge.
  initial begin
    vec_t it;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk({it.nm, " tc"}, {7'd0, tc}, {7'd0, it.exp_tc});
        if (it.c16) chk({it.nm, " tc16"}, {7'd0, tc16}, {7'd0, it.exp_tc16});
        @(posedge clk);
        #1;
        chk({it.nm, " Q"}, {4'd0, q}, {4'd0, it.exp_q});
        if (it.c2)  chk({it.nm, " Q2Q1"}, {q2, q}, {it.exp_q2, it.exp_q});
        if (it.c16) chk({it.nm, " Q16"}, {4'd0, q16}, {4'd0, it.exp_q16});
`ifdef SYN_UP_COUNTER_OVF_EN
        if (it.co)  chk({it.nm, " ovf"}, {7'd0, ovf}, {7'd0, it.exp_ovf});
`endif
      end
    end
  end

  initial begin
    vec_t v;

    // Reset overrides load/en
    v = mk(1, 1, 1, 4'd7, 0, 4'd0, "rst1"); v.co = 1; step(v);
    v = mk(1, 1, 1, 4'd7, 0, 4'd0, "rst2"); v.co = 1; step(v);

    // Free count 1..9,0,1,2; tc only while Q=9
    for (int i = 1; i <= 12; i++) begin
      v = mk(0, 1, 0, 4'd0, (i == 10), 4'(i % 10), "count");
      step(v);
    end

    // Load has priority over en, clamps out-of-range values, suppresses tc
    step(mk(0, 1, 1, 4'd5,  0, 4'd5, "load5"));
    step(mk(0, 1, 1, 4'd12, 0, 4'd9, "load12clamp"));
    step(mk(0, 1, 1, 4'd9,  0, 4'd9, "load9atmax"));
    step(mk(0, 0, 0, 4'd3,  0, 4'd9, "hold9"));

    // Enable toggling from 8
    step(mk(0, 0, 1, 4'd8, 0, 4'd8, "load8"));
    step(mk(0, 1, 0, 4'd0, 0, 4'd9, "tog_en1"));
    step(mk(0, 0, 0, 4'd0, 0, 4'd9, "tog_en0"));
    step(mk(0, 1, 0, 4'd0, 1, 4'd0, "tog_wrap"));
    step(mk(0, 0, 0, 4'd0, 0, 4'd0, "tog_hold0"));

    // Mid-count reset with tc terms true: tc high, Q still cleared
    step(mk(0, 0, 1, 4'd9, 0, 4'd9, "preload9"));
    v = mk(1, 1, 0, 4'd0, 1, 4'd0, "rst_at_tc"); v.co = 1; step(v);

    // Two-stage decade cascade 00..99 -> 00
    for (int i = 1; i <= 100; i++) begin
      v = mk(0, 1, 0, 4'd0, (i % 10 == 0), 4'(i % 10), "cascade");
      v.c2 = 1; v.exp_q2 = 4'((i / 10) % 10);
      step(v);
    end

    // MODULUS=16 alongside MODULUS=10 on shared inputs
    v = mk(1, 0, 0, 4'd0, 0, 4'd0, "m16_rst"); v.c16 = 1; step(v);
    v = mk(0, 0, 1, 4'd14, 0, 4'd9, "m16_load14"); v.c16 = 1; v.exp_q16 = 4'd14; step(v);
    v = mk(0, 1, 0, 4'd0, 1, 4'd0, "m16_to15"); v.c16 = 1; v.exp_q16 = 4'd15; step(v);
    v = mk(0, 1, 0, 4'd0, 0, 4'd1, "m16_wrap"); v.c16 = 1; v.exp_tc16 = 1; v.exp_q16 = 4'd0; step(v);
    v = mk(0, 0, 1, 4'd15, 0, 4'd9, "m16_load15"); v.c16 = 1; v.exp_q16 = 4'd15; step(v);

`ifdef SYN_UP_COUNTER_OVF_EN
    v = mk(1, 0, 0, 4'd0, 0, 4'd0, "ovf_rst"); v.co = 1; step(v);
    v = mk(0, 0, 1, 4'd9, 0, 4'd9, "ovf_pre"); v.co = 1; step(v);
    v = mk(0, 1, 0, 4'd0, 1, 4'd0, "ovf_set"); v.co = 1; v.exp_ovf = 1; step(v);
    v = mk(0, 0, 0, 4'd0, 0, 4'd0, "ovf_sticky"); v.co = 1; v.exp_ovf = 1; step(v);
    v = mk(0, 0, 0, 4'd0, 0, 4'd0, "ovf_clr"); v.clr = 1; v.co = 1; step(v);
    v = mk(0, 0, 1, 4'd9, 0, 4'd9, "ovf_pre2"); v.co = 1; step(v);
    v = mk(0, 1, 0, 4'd0, 1, 4'd0, "ovf_setwins"); v.clr = 1; v.co = 1; v.exp_ovf = 1; step(v);
    v = mk(1, 0, 0, 4'd0, 0, 4'd0, "ovf_rstclr"); v.co = 1; step(v);
`endif

    @(negedge clk);
    reset = 1'b0; en = 1'b0; load = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tot++;
    if (sb.size() != 0) $display("FAIL drain: got %0d pending expected 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
